// File: rtl/coin_pulse_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_conditioner_if
//  Description : Raw coin-sensor inputs and conditioned coin pulse outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coin_pulse_conditioner_if;
    logic coinOneRaw;
    logic coinHalfRaw;
    logic coinEn;
    logic piOne;
    logic piHalf;
    logic lostPulse;

    modport master (
        output coinOneRaw, coinHalfRaw, coinEn,
        input  piOne, piHalf, lostPulse
    );

    modport slave (
        input  coinOneRaw, coinHalfRaw, coinEn,
        output piOne, piHalf, lostPulse
    );
endinterface
`default_nettype wire

// File: rtl/coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_conditioner
//  Description : Synchronises and debounces two coin sensors, queues one coin
//                per channel and emits spaced single-cycle coin pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                     sys_clk,
    input  logic                     sysRstN,
    coin_pulse_conditioner_if.slave  bus
);

    localparam int             c_GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    // Channel 0 is the 1-yuan sensor, channel 1 the 0.5-yuan sensor.
    logic [1:0] w_raw;
    logic [1:0] w_pend;
    logic [1:0] w_clr;
    logic [1:0] w_lost_ch;

    assign w_raw = {bus.coinHalfRaw, bus.coinOneRaw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic             r_s1;
            logic             r_s2;
            logic             r_db;
            logic [CNT_W-1:0] r_cnt;
            logic             r_pend;
            logic             w_rise;

            // A rising edge is recognised on the very edge that writes db.
            assign w_rise        = r_s2 & ~r_db & (r_cnt == c_CNT_MAX);
            assign w_pend[gi]    = r_pend;
            assign w_lost_ch[gi] = w_rise & (~bus.coinEn | (r_pend & ~w_clr[gi]));

            always_ff @(posedge sys_clk or negedge sysRstN) begin
                if (!sysRstN) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_db   <= 1'b0;
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A coin landing on the edge its predecessor is emitted is queued.
                    if (w_rise && bus.coinEn && (!r_pend || w_clr[gi])) begin
                        r_pend <= 1'b1;
                    end else if (w_clr[gi]) begin
                        r_pend <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               r_pi_one;
    logic               r_pi_half;
    logic               r_lost;
    logic               w_one_nxt;
    logic               w_half_nxt;

    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            r_state   <= ST_IDLE;
            r_gap     <= '0;
            r_pi_one  <= 1'b0;
            r_pi_half <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_pi_one  <= w_one_nxt;
            r_pi_half <= w_half_nxt;
            r_lost    <= |w_lost_ch;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_one_nxt   = 1'b0;
        w_half_nxt  = 1'b0;
        w_clr       = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_pend[0]) begin
                    w_one_nxt   = 1'b1;
                    w_clr[0]    = 1'b1;
                    w_gap_nxt   = c_GAP_LOAD;
                    w_state_nxt = ST_GAP;
                end else if (w_pend[1]) begin
                    w_half_nxt  = 1'b1;
                    w_clr[1]    = 1'b1;
                    w_gap_nxt   = c_GAP_LOAD;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap - 1'b1;
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.piOne     = r_pi_one;
    assign bus.piHalf    = r_pi_half;
    assign bus.lostPulse = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_pulse_conditioner
//  Description : Directed and randomised stimulus against a cycle-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_pulse_conditioner;

    localparam int D = 4;
    localparam int G = 12;

    logic sys_clk = 1'b0;
    logic sysRstN = 1'b0;

    always #5 sys_clk = ~sys_clk;

    coin_pulse_conditioner_if bus ();

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .GAP_CYCLES      (G)
    ) u_dut (
        .sys_clk (sys_clk),
        .sysRstN (sysRstN),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: sensor histories, queued coins and the earliest cycle the
    // emitter may fire again.
    logic [1:0]   m_s1, m_s2, m_db, m_pend;
    logic [D-1:0] m_hist [2];
    int           m_cyc  = 0;
    int           m_free = 0;
    logic         exp_one, exp_half, exp_lost;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0;
        m_hist[0] = '0; m_hist[1] = '0;
        m_free = 0;
        exp_one = 1'b0; exp_half = 1'b0; exp_lost = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] rose;
        logic [1:0] clr;
        m_cyc++;
        rose = '0;
        // The level flips once the last D synchronised samples all disagree with it.
        for (int c = 0; c < 2; c++) begin
            m_hist[c] = {m_hist[c][D-2:0], m_s2[c]};
            if (m_hist[c] == {D{~m_db[c]}}) begin
                m_db[c] = ~m_db[c];
                rose[c] = m_db[c];
            end
        end
        exp_one = 1'b0; exp_half = 1'b0; exp_lost = 1'b0; clr = '0;
        if (m_cyc >= m_free) begin
            if (m_pend[0]) begin
                exp_one = 1'b1; clr[0] = 1'b1; m_free = m_cyc + G + 1;
            end else if (m_pend[1]) begin
                exp_half = 1'b1; clr[1] = 1'b1; m_free = m_cyc + G + 1;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (rose[c]) begin
                if (!bus.coinEn || (m_pend[c] && !clr[c])) exp_lost = 1'b1;
                else begin m_pend[c] = 1'b1; clr[c] = 1'b0; end
            end
            if (clr[c]) m_pend[c] = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = {bus.coinHalfRaw, bus.coinOneRaw};
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        if (sysRstN) model_step();
        else         model_reset();
        @(negedge sys_clk);
        check_eq("piOne", bus.piOne, exp_one);
        check_eq("piHalf", bus.piHalf, exp_half);
        check_eq("lostPulse", bus.lostPulse, exp_lost);
        check_eq("both_high", bus.piOne & bus.piHalf, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int   hold [2];
    int   en_hold;
    logic lvl [2];

    initial begin
        bus.coinOneRaw  = 1'b0;
        bus.coinHalfRaw = 1'b0;
        bus.coinEn      = 1'b1;
        model_reset();
        run(3);
        check_eq("rst_piOne", bus.piOne, 0);
        check_eq("rst_piHalf", bus.piHalf, 0);
        check_eq("rst_lost", bus.lostPulse, 0);
        sysRstN = 1'b1;
        run(4);

        // Clean 1-yuan press.
        bus.coinOneRaw = 1'b1; run(20);
        bus.coinOneRaw = 1'b0; run(20);

        // Bouncy half coin, then a settled press.
        for (int i = 0; i < 6; i++) begin
            bus.coinHalfRaw = ~bus.coinHalfRaw; run(1);
        end
        bus.coinHalfRaw = 1'b1; run(15);
        bus.coinHalfRaw = 1'b0; run(20);

        // Glitches shorter than the debounce window.
        for (int i = 0; i < 3; i++) begin
            bus.coinOneRaw = 1'b1; run(3);
            bus.coinOneRaw = 1'b0; run(3);
        end
        run(10);

        // Simultaneous coins.
        bus.coinOneRaw = 1'b1; bus.coinHalfRaw = 1'b1; run(25);
        bus.coinOneRaw = 1'b0; bus.coinHalfRaw = 1'b0; run(20);

        // Half coin ahead, then a 1-yuan coin pressed twice while waiting.
        bus.coinHalfRaw = 1'b1; run(2);
        bus.coinOneRaw  = 1'b1; run(5);
        bus.coinOneRaw  = 1'b0; run(6);
        bus.coinOneRaw  = 1'b1; run(10);
        bus.coinOneRaw  = 1'b0; bus.coinHalfRaw = 1'b0; run(40);

        // Insertion while disabled, then a normal one.
        bus.coinEn = 1'b0; bus.coinOneRaw = 1'b1; run(12);
        bus.coinOneRaw = 1'b0; run(10);
        bus.coinEn = 1'b1; bus.coinOneRaw = 1'b1; run(12);
        bus.coinOneRaw = 1'b0; run(20);

        // Reset while the half coin is still queued behind an emitted 1-yuan.
        bus.coinOneRaw = 1'b1; bus.coinHalfRaw = 1'b1;
        for (int i = 0; i < 40 && !bus.piOne; i++) cycle();
        check_eq("midq_reach", bus.piOne, 1);
        #2 sysRstN = 1'b0;
        #1;
        check_eq("midq_rst_piOne", bus.piOne, 0);
        check_eq("midq_rst_piHalf", bus.piHalf, 0);
        model_reset();
        bus.coinOneRaw = 1'b0; bus.coinHalfRaw = 1'b0;
        run(2);
        sysRstN = 1'b1;
        run(40);

        // Randomised sensor activity.
        hold[0] = 0; hold[1] = 0; en_hold = 0;
        lvl[0] = 1'b0; lvl[1] = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 14));
                end
                hold[c]--;
            end
            if (en_hold == 0) begin
                bus.coinEn = ($urandom_range(0, 4) != 0);
                en_hold    = int'($urandom_range(10, 60));
            end
            en_hold--;
            bus.coinOneRaw  = lvl[0];
            bus.coinHalfRaw = lvl[1];
            run(1);
        end
        bus.coinOneRaw = 1'b0; bus.coinHalfRaw = 1'b0;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
- Upstream front end for the vending FSM. Converts two raw, bouncy, asynchronous coin-sensor lines (1 yuan, 0.5 yuan) into clean single-cycle `piOne`/`piHalf` pulses in the `sys_clk` domain.
- Guarantees at most one coin pulse per cycle and never both pulses in the same cycle.
- Queues a coin that arrives while the other is being emitted, so no insertion is merged or dropped silently.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before a sensor level change is accepted (min 2)
CNT_W, 10, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
GAP_CYCLES, 2, minimum number of all-low cycles between any two output pulses (min 1)

Ports:
sys_clk  input  1  system clock
sysRstN  input  1  asynchronous active-low reset
coinOneRaw  input  1  raw 1-yuan sensor, active high, asynchronous, bouncy
coinHalfRaw  input  1  raw 0.5-yuan sensor, active high, asynchronous, bouncy
coinEn  input  1  1 = accept coins; 0 = new insertions rejected
piOne  output  1  one-cycle pulse per accepted 1-yuan coin
piHalf  output  1  one-cycle pulse per accepted 0.5-yuan coin
lostPulse  output  1  one-cycle pulse when a coin is discarded (pending overflow or coinEn=0)

Behaviour:
- Clock and reset: one clock `sys_clk`. Reset is asynchronous and active-low on `sysRstN`. All registers clear on reset.
- Reset values: `piOne`=0, `piHalf`=0, `lostPulse`=0. Synchronizers, debounced levels, counters and pending bits are all 0. Emitter state is IDLE.
- Synchronizer: each raw input passes through its own 2-FF synchronizer (s1, s2).
- Debounce, per channel: registers `db` (level) and `cnt`.
  - s2 == db: `cnt` <= 0.
  - s2 != db and `cnt` == DEBOUNCE_CYCLES-1: `db` <= s2 and `cnt` <= 0.
  - s2 != db otherwise: `cnt` increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is discarded.
- Coin event: a `db` 0->1 transition is an event, detected on the same edge `db` is written. 1->0 transitions are ignored.
- Event with coinEn=1 and the channel's pending bit clear: set the pending bit.
- Event with coinEn=0, or pending bit already set and not being cleared on this edge: `lostPulse`=1 for one cycle; pending is unchanged.
- Event on the same edge the emitter clears that channel's pending bit: the pending bit stays set (the new coin is queued, not lost).
- Emitter FSM, states IDLE and GAP.
  - IDLE, pendOne=1: `piOne` <= 1, clear pendOne, gapCnt <= GAP_CYCLES, go to GAP.
  - IDLE, pendHalf=1 and pendOne=0: same action on `piHalf`. pendOne has priority over pendHalf.
  - IDLE, neither pending: outputs 0, stay in IDLE.
  - GAP: outputs 0. gapCnt decrements; return to IDLE when it reaches 1 after decrement... more precisely, leave GAP after exactly GAP_CYCLES cycles.
  - Resulting spacing: pulses are at least GAP_CYCLES+1 edges apart.
- Latency: let edge k be the first edge at which a raw line is stably high.
  - s2=1 after edge k+1.
  - `db` and pending set at edge k+1+DEBOUNCE_CYCLES.
  - Output pulse is high between edges k+2+DEBOUNCE_CYCLES and k+3+DEBOUNCE_CYCLES, provided the emitter is IDLE.
- Simultaneous coins: both pending bits set on the same edge t. `piOne` is high after edge t+1. `piHalf` is high after edge t+2+GAP_CYCLES.
- coinEn low mid-operation: coins already pending are still emitted. Only new events are rejected.
- Reset mid-operation: pending coins are lost without a `lostPulse`, and outputs drop immediately.
- Sensor held high through reset release: `db` restarts at 0, so one pulse is produced after the debounce delay. This is intentional; a stuck sensor is reported to the FSM as a coin.
- Counter widths never wrap: `cnt` saturates at DEBOUNCE_CYCLES-1 before rollover by construction.

Test Plan:
1. Clean press. DEBOUNCE_CYCLES=4, GAP_CYCLES=2; coinOneRaw rises before edge 10 and stays high for 20 cycles -> `piOne` high for exactly one cycle, after edge 16. `piHalf`=0 and `lostPulse`=0 throughout.
2. Bounce. coinHalfRaw toggles every cycle 6 times, then stays high -> exactly one `piHalf` pulse, 6 edges after the last toggle's synchronized level stabilises. Glitches of 3 cycles alone -> no pulse.
3. Simultaneous. Both raw lines rise on the same cycle -> `piOne` at edge t+1, `piHalf` at edge t+4 (GAP_CYCLES=2). Outputs are never high together.
4. Overflow. Two 1-yuan presses (release ≥4 cycles, re-press) while GAP_CYCLES=20 and a half coin ahead in the queue -> second 1-yuan press raises `lostPulse` for one cycle. Exactly one `piOne` follows the `piHalf`.
5. Disable. coinEn=0 during a 1-yuan press -> no `piOne`, one `lostPulse`. A press after coinEn returns to 1 -> normal `piOne`.
6. Reset mid-queue. Assert sysRstN=0 while both pending bits are set -> `piOne`/`piHalf` go to 0 asynchronously. After release with raw lines low, no pulses occur.
